// File: rtl/sram_like_slave.sv
// sram_like_slave
// ---------------
// Responder end of the SRAM-like bus, backed by a word-organised memory of
// 2**ADDR_W 32-bit words. Requests are accepted one per cycle and answered
// in acceptance order, no earlier than LATENCY edges after acceptance.
// Up to DEPTH transactions may be outstanding at once.
//
// Handshake: a request transfers on a rising edge where req and addr_ok are
// both high. The initiator holds req/wr/size/wstrb/addr/wdata stable until
// that edge. Nothing is sampled before acceptance. data_ok is a one-cycle
// pulse per transaction that the initiator must always take; it is never
// stalled.
//
// Ports:
//   clk      in   1   clock
//   reset    in   1   synchronous, active-high reset
//   req      in   1   initiator request valid
//   wr       in   1   1 = write, 0 = read
//   size     in   2   transfer size; recorded only, lanes come from wstrb
//   wstrb    in   4   write byte enables, bit i -> wdata[8i+7:8i]
//   addr     in  32   byte address; word index is addr[ADDR_W+1:2]
//   wdata    in  32   write data
//   stall_i  in   1   forces addr_ok low
//   addr_ok  out  1   request accepted this cycle
//   data_ok  out  1   one transaction completes this cycle
//   rdata    out 32   read data while data_ok=1, otherwise 0
//   busy     out  1   at least one transaction outstanding
module sram_like_slave #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        stall_i,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [3:0]       CD_INIT  = 4'(LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    // Pending entries: {is_write, data, countdown}, ring-addressed.
    logic [DEPTH-1:0] ent_wr;
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_cd   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] word_idx;
    logic              accept;
    logic              head_valid;
    logic              pop;

    // Size, the aliasing upper address bits and the byte offset carry no
    // behaviour in this memory.
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign word_idx = addr[ADDR_W+1:2];

    // count covers queued entries plus the one being presented on data_ok;
    // that presented entry frees its slot at the end of its data_ok cycle,
    // so a full queue can still accept while data_ok is high.
    assign addr_ok = req & ~stall_i & ~reset & ~((count == CNT_FULL) & ~data_ok);
    assign accept  = req & addr_ok;

    // Queued (not yet presented) entries = count - data_ok.
    assign head_valid = (count != CNT_W'(data_ok));
    assign pop        = head_valid & (ent_cd[rd_ptr] == 4'd0);

    always_comb begin
        count_next = count;
        if (accept && !data_ok) begin
            count_next = count + 1'b1;
        end else if (!accept && data_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            data_ok <= pop;
            rdata   <= (pop && !ent_wr[rd_ptr]) ? ent_data[rd_ptr] : '0;
            count   <= count_next;
            busy    <= (count_next != '0);
        end
    end

    // Entry payloads need no reset: count and the pointers decide which
    // slots are live. All countdowns tick together and saturate at zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_cd[i] != 4'd0) begin
                ent_cd[i] <= ent_cd[i] - 4'd1;
            end
        end
        if (accept) begin
            ent_wr[wr_ptr]   <= wr;
            ent_data[wr_ptr] <= mem[word_idx];
            ent_cd[wr_ptr]   <= CD_INIT;
        end
    end

    // Memory contents survive reset; only enabled byte lanes change.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Testbench for sram_like_slave. Three instances with different LATENCY /
// DEPTH settings share clock and reset; each has its own bus inputs.
//   inst 0: LATENCY=2, DEPTH=4 (defaults)
//   inst 1: LATENCY=8, DEPTH=4
//   inst 2: LATENCY=1, DEPTH=2
// A transaction-level model predicts, per instance and per cycle, addr_ok,
// data_ok, rdata and busy from completion-edge arithmetic.
module tb_sram_like_slave;

    logic clk = 1'b0;
    logic reset;

    logic        req_s   [3];
    logic        wr_s    [3];
    logic [1:0]  size_s  [3];
    logic [3:0]  wstrb_s [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic        stall_s [3];
    logic        addr_ok_w [3];
    logic        data_ok_w [3];
    logic [31:0] rdata_w   [3];
    logic        busy_w    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_slave #(.ADDR_W(12), .LATENCY(2), .DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]),
        .wstrb(wstrb_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .stall_i(stall_s[0]),
        .addr_ok(addr_ok_w[0]), .data_ok(data_ok_w[0]), .rdata(rdata_w[0]), .busy(busy_w[0])
    );

    sram_like_slave #(.ADDR_W(12), .LATENCY(8), .DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]),
        .wstrb(wstrb_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .stall_i(stall_s[1]),
        .addr_ok(addr_ok_w[1]), .data_ok(data_ok_w[1]), .rdata(rdata_w[1]), .busy(busy_w[1])
    );

    sram_like_slave #(.ADDR_W(12), .LATENCY(1), .DEPTH(2)) u_c (
        .clk(clk), .reset(reset), .req(req_s[2]), .wr(wr_s[2]), .size(size_s[2]),
        .wstrb(wstrb_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]), .stall_i(stall_s[2]),
        .addr_ok(addr_ok_w[2]), .data_ok(data_ok_w[2]), .rdata(rdata_w[2]), .busy(busy_w[2])
    );

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int dep_of(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    logic [31:0] mmem   [3][4096];
    bit          mknown [3][4096];
    int          m_done [3][16];   // edge after which data_ok is high
    logic [31:0] m_rd   [3][16];
    bit          m_rdk  [3][16];
    int          m_head [3];
    int          m_cnt  [3];
    int          m_last [3];
    bit          pend_acc [3];
    bit          pend_rst;
    logic        p_wr    [3];
    logic [31:0] p_addr  [3];
    logic [31:0] p_wdata [3];
    logic [3:0]  p_wstrb [3];
    int          edge_n = 0;

    // ---------------- observation log for directed checks ----------------
    int          log_inst = -1;
    int          acc_cyc[$];
    int          dok_cyc[$];
    logic [31:0] dok_rd[$];

    task automatic log_start(input int i);
        acc_cyc.delete();
        dok_cyc.delete();
        dok_rd.delete();
        log_inst = i;
    endtask

    // ---------------- model + compare process ----------------
    initial begin : monitor
        int idx;
        int slot;
        int done;
        bit head_now;
        bit exp_aok;
        pend_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_head[i] = 0; m_last[i] = 0; pend_acc[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            for (int i = 0; i < 3; i++) begin
                if (pend_rst) begin
                    m_cnt[i] = 0; m_head[i] = 0; m_last[i] = 0;
                end else if (pend_acc[i]) begin
                    idx  = int'(p_addr[i][13:2]);
                    done = edge_n + lat_of(i);
                    if (m_last[i] + 1 > done) done = m_last[i] + 1;
                    m_last[i] = done;
                    slot = (m_head[i] + m_cnt[i]) % 16;
                    m_done[i][slot] = done;
                    if (p_wr[i]) begin
                        m_rd[i][slot]  = 32'h0;
                        m_rdk[i][slot] = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (p_wstrb[i][b]) mmem[i][idx][8*b +: 8] = p_wdata[i][8*b +: 8];
                        end
                        if (p_wstrb[i] == 4'hF) mknown[i][idx] = 1'b1;
                    end else begin
                        m_rd[i][slot]  = mmem[i][idx];
                        m_rdk[i][slot] = mknown[i][idx];
                    end
                    m_cnt[i]++;
                end
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                head_now = (m_cnt[i] != 0) && (m_done[i][m_head[i]] == edge_n);
                exp_aok  = req_s[i] && !stall_s[i] && !reset &&
                           ((m_cnt[i] < dep_of(i)) || head_now);
                chk($sformatf("addr_ok[%0d]", i), {31'h0, addr_ok_w[i]}, {31'h0, exp_aok});
                chk($sformatf("data_ok[%0d]", i), {31'h0, data_ok_w[i]}, {31'h0, head_now});
                chk($sformatf("busy[%0d]", i), {31'h0, busy_w[i]}, (m_cnt[i] != 0) ? 32'h1 : 32'h0);
                if (head_now) begin
                    if (m_rdk[i][m_head[i]]) begin
                        chk($sformatf("rdata[%0d]", i), rdata_w[i], m_rd[i][m_head[i]]);
                    end
                    m_head[i] = (m_head[i] + 1) % 16;
                    m_cnt[i]--;
                end else begin
                    chk($sformatf("rdata_idle[%0d]", i), rdata_w[i], 32'h0);
                end
                if (log_inst == i) begin
                    if (data_ok_w[i] === 1'b1) begin
                        dok_cyc.push_back(edge_n);
                        dok_rd.push_back(rdata_w[i]);
                    end
                    if (req_s[i] && addr_ok_w[i] === 1'b1) acc_cyc.push_back(edge_n + 1);
                end
                pend_acc[i] = exp_aok;
                p_wr[i]     = wr_s[i];
                p_addr[i]   = addr_s[i];
                p_wdata[i]  = wdata_s[i];
                p_wstrb[i]  = wstrb_s[i];
            end
            pend_rst = reset;
        end
    end

    // ---------------- driver tasks ----------------
    // Called and returning at posedge+1; returns just after the accept edge.
    task automatic bus(input int i, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        bit got;
        got = 1'b0;
        req_s[i] = 1'b1; wr_s[i] = w; addr_s[i] = a; wdata_s[i] = d; wstrb_s[i] = s;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (addr_ok_w[i] === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
        end
        chk($sformatf("accept_timeout[%0d]", i), {31'h0, got}, 32'h1);
        req_s[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy_w[i] !== 1'b0 && t < 200);
        chk($sformatf("idle_timeout[%0d]", i), (t < 200) ? 32'h1 : 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_s[i] = 1'b1; wr_s[i] = 1'b1; size_s[i] = 2'd2; wstrb_s[i] = 4'hF;
            addr_s[i] = 32'h0; wdata_s[i] = 32'hA5A5_0000; stall_s[i] = 1'b0;
        end

        // Reset held three edges with req high; first request taken right after.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        req_s[1] = 1'b0;
        req_s[2] = 1'b0;
        @(negedge clk);
        chk("first_accept", {31'h0, addr_ok_w[0]}, 32'h1);
        @(posedge clk);
        #1;
        req_s[0] = 1'b0;
        wait_idle(0);

        // Single write then read, LATENCY=2.
        log_start(0);
        bus(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        bus(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        wait_idle(0);
        chk("t1_dok_count", dok_cyc.size(), 32'd2);
        if (dok_cyc.size() == 2 && acc_cyc.size() == 2) begin
            chk("t1_write_rdata", dok_rd[0], 32'h0);
            chk("t1_read_rdata", dok_rd[1], 32'hDEAD_BEEF);
            chk("t1_read_gap", dok_cyc[1] - dok_cyc[0], 32'd1);
            chk("t1_latency", dok_cyc[0] - acc_cyc[0], 32'd2);
        end

        // Byte strobes and address aliasing.
        log_start(0);
        bus(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF);
        bus(0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        bus(0, 1'b0, 32'h0000_4020, 32'h0, 4'h0);
        wait_idle(0);
        chk("t2_dok_count", dok_cyc.size(), 32'd3);
        if (dok_rd.size() == 3) chk("t2_alias_rdata", dok_rd[2], 32'h11BB_33DD);

        // Full queue, LATENCY=8, DEPTH=4.
        for (int k = 0; k < 5; k++) bus(1, 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k), 4'hF);
        wait_idle(1);
        log_start(1);
        for (int k = 0; k < 5; k++) bus(1, 1'b0, 32'(4 * k), 32'h0, 4'h0);
        wait_idle(1);
        chk("t3_dok_count", dok_cyc.size(), 32'd5);
        chk("t3_acc_count", acc_cyc.size(), 32'd5);
        if (dok_cyc.size() == 5 && acc_cyc.size() == 5) begin
            chk("t3_acc1", acc_cyc[1] - acc_cyc[0], 32'd1);
            chk("t3_acc3", acc_cyc[3] - acc_cyc[0], 32'd3);
            chk("t3_first_dok", dok_cyc[0] - acc_cyc[0], 32'd8);
            chk("t3_fifth_acc", acc_cyc[4] - dok_cyc[0], 32'd1);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t3_rdata%0d", k), dok_rd[k], 32'h1000_0000 + 32'(k));
            end
        end

        // Back-pressure, then 16-read stream on LATENCY=1, DEPTH=2.
        for (int k = 0; k < 16; k++) begin
            bus(2, 1'b1, 32'h100 + 32'(4 * k), 32'hC0DE_0000 + 32'(k) * 32'h111, 4'hF);
        end
        wait_idle(2);
        log_start(2);
        stall_s[2] = 1'b1;
        req_s[2] = 1'b1; wr_s[2] = 1'b0; addr_s[2] = 32'h100; wstrb_s[2] = 4'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_stall_addr_ok", {31'h0, addr_ok_w[2]}, 32'h0);
            chk("t4_stall_busy", {31'h0, busy_w[2]}, 32'h0);
        end
        @(posedge clk);
        #1;
        stall_s[2] = 1'b0;
        for (int k = 0; k < 16; k++) bus(2, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0);
        wait_idle(2);
        chk("t4_dok_count", dok_cyc.size(), 32'd16);
        if (dok_cyc.size() == 16 && acc_cyc.size() == 16) begin
            chk("t4_latency", dok_cyc[0] - acc_cyc[0], 32'd1);
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("t4_cycle%0d", k), dok_cyc[k] - dok_cyc[0], 32'(k));
                chk($sformatf("t4_rdata%0d", k), dok_rd[k], 32'hC0DE_0000 + 32'(k) * 32'h111);
            end
        end

        // Reset mid-flight on LATENCY=8: three reads dropped.
        log_start(1);
        bus(1, 1'b0, 32'h0, 32'h0, 4'h0);
        bus(1, 1'b0, 32'h4, 32'h0, 4'h0);
        bus(1, 1'b0, 32'h8, 32'h0, 4'h0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_busy_after_reset", {31'h0, busy_w[1]}, 32'h0);
        repeat (12) @(posedge clk);
        #1;
        chk("t5_no_dok", dok_cyc.size(), 32'd0);
        log_start(1);
        bus(1, 1'b0, 32'h8, 32'h0, 4'h0);
        wait_idle(1);
        chk("t5_next_count", dok_cyc.size(), 32'd1);
        if (dok_cyc.size() == 1 && acc_cyc.size() == 1) begin
            chk("t5_next_rdata", dok_rd[0], 32'h1000_0002);
            chk("t5_next_latency", dok_cyc[0] - acc_cyc[0], 32'd8);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
